// File: rtl/spu32_cpu_alu_arbiter.sv
// Two-port arbiter in front of the shared spu32 ALU. Accepts one operation at
// a time, latches it, holds the ALU enable while the ALU reports busy, and
// returns the result to the owning port as a one-cycle pulse.
module spu32_cpu_alu_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0_valid,
  input  logic [3:0]  I_req0_op,
  input  logic [31:0] I_req0_s1,
  input  logic [31:0] I_req0_s2,
  output logic        O_req0_ready,
  output logic        O_rsp0_valid,
  input  logic        I_req1_valid,
  input  logic [3:0]  I_req1_op,
  input  logic [31:0] I_req1_s1,
  input  logic [31:0] I_req1_s2,
  output logic        O_req1_ready,
  output logic        O_rsp1_valid,
  output logic [31:0] O_rsp_data,
  output logic        O_alu_en,
  output logic [3:0]  O_alu_op,
  output logic [31:0] O_alu_s1,
  output logic [31:0] O_alu_s2,
  input  logic        I_alu_busy,
  input  logic [31:0] I_alu_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWait} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic        grant;

  // Arbitration: a lone request wins; on a tie either rotate or favour port 0.
  always_comb begin
    if (I_req0_valid && I_req1_valid) begin
      grant = RR_ENABLE ? ~last_grant_q : 1'b0;
    end else begin
      grant = I_req1_valid;
    end
  end

  // Next-state and handshake/ALU-control outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    O_req0_ready = 1'b0;
    O_req1_ready = 1'b0;
    O_rsp0_valid = 1'b0;
    O_rsp1_valid = 1'b0;
    O_alu_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (I_req0_valid || I_req1_valid) begin
          O_req0_ready = ~grant;
          O_req1_ready = grant;
          owner_d      = grant;
          last_grant_d = grant;
          op_d         = grant ? I_req1_op : I_req0_op;
          s1_d         = grant ? I_req1_s1 : I_req0_s1;
          s2_d         = grant ? I_req1_s2 : I_req0_s2;
          state_d      = StExec;
        end
      end
      StExec: begin
        O_alu_en = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (I_alu_busy) begin
          // Keep re-issuing the same latched op until the multiplier is done.
          O_alu_en = 1'b1;
        end else begin
          O_rsp0_valid = ~owner_q;
          O_rsp1_valid = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset wins: nothing is accepted, issued or answered in a reset cycle.
    if (I_reset) begin
      O_req0_ready = 1'b0;
      O_req1_ready = 1'b0;
      O_rsp0_valid = 1'b0;
      O_rsp1_valid = 1'b0;
      O_alu_en     = 1'b0;
    end
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 4'd0;
      s1_q         <= 32'd0;
      s2_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
    end
  end

  assign O_alu_op   = op_q;
  assign O_alu_s1   = s1_q;
  assign O_alu_s2   = s2_q;
  assign O_rsp_data = I_alu_data;

endmodule

// File: tb/tb_spu32_cpu_alu_arbiter.sv
// Self-checking bench: directed table, tie-breaking sequences, randomized
// traffic against a scoreboard, and reset during a busy multiply.
module tb_spu32_cpu_alu_arbiter;

  localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3;
  localparam logic [3:0] OpXor = 4'd4, OpSlt = 4'd5, OpSltu = 4'd6, OpShl = 4'd7;
  localparam logic [3:0] OpShr = 4'd8, OpSra = 4'd9, OpMul = 4'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req_op [2];
  logic [31:0] req_s1 [2];
  logic [31:0] req_s2 [2];

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic [1:0]  ready_rr, rsp_rr, ready_fp, rsp_fp;
  logic [31:0] data_rr, data_fp;
  logic [1:0]  alu_en, alu_busy;
  logic [3:0]  alu_op [2];
  logic [31:0] alu_s1 [2];
  logic [31:0] alu_s2 [2];
  logic [31:0] alu_data [2];
  int          busy_cnt [2];
  int          busy_len = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spu32_cpu_alu_arbiter #(.RR_ENABLE(1'b1)) dut (
    .I_clk(clk), .I_reset(reset),
    .I_req0_valid(req_valid[0]), .I_req0_op(req_op[0]), .I_req0_s1(req_s1[0]),
    .I_req0_s2(req_s2[0]), .O_req0_ready(ready_rr[0]), .O_rsp0_valid(rsp_rr[0]),
    .I_req1_valid(req_valid[1]), .I_req1_op(req_op[1]), .I_req1_s1(req_s1[1]),
    .I_req1_s2(req_s2[1]), .O_req1_ready(ready_rr[1]), .O_rsp1_valid(rsp_rr[1]),
    .O_rsp_data(data_rr), .O_alu_en(alu_en[0]), .O_alu_op(alu_op[0]),
    .O_alu_s1(alu_s1[0]), .O_alu_s2(alu_s2[0]), .I_alu_busy(alu_busy[0]),
    .I_alu_data(alu_data[0])
  );

  spu32_cpu_alu_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .I_clk(clk), .I_reset(reset),
    .I_req0_valid(req_valid[0]), .I_req0_op(req_op[0]), .I_req0_s1(req_s1[0]),
    .I_req0_s2(req_s2[0]), .O_req0_ready(ready_fp[0]), .O_rsp0_valid(rsp_fp[0]),
    .I_req1_valid(req_valid[1]), .I_req1_op(req_op[1]), .I_req1_s1(req_s1[1]),
    .I_req1_s2(req_s2[1]), .O_req1_ready(ready_fp[1]), .O_rsp1_valid(rsp_fp[1]),
    .O_rsp_data(data_fp), .O_alu_en(alu_en[1]), .O_alu_op(alu_op[1]),
    .O_alu_s1(alu_s1[1]), .O_alu_s2(alu_s2[1]), .I_alu_busy(alu_busy[1]),
    .I_alu_data(alu_data[1])
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpSltu:  return (a < b) ? 32'd1 : 32'd0;
      OpShl:   return a << b[4:0];
      OpShr:   return a >> b[4:0];
      OpSra:   return 32'($signed(a) >>> b[4:0]);
      OpMul:   return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU per instance: result registered on enable, busy for
  // busy_len cycles after the first enabled cycle of an operation.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        alu_data[k] <= 32'd0;
        busy_cnt[k] <= 0;
      end else if (alu_en[k]) begin
        alu_data[k] <= alu_fn(alu_op[k], alu_s1[k], alu_s2[k]);
        busy_cnt[k] <= (busy_cnt[k] == 0) ? busy_len : busy_cnt[k] - 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) alu_busy[k] = (busy_cnt[k] != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive point of a cycle; outputs are sampled 1 time unit later.
  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    int          blen;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  bit [1:0] pend = 2'b00;

  // One request on a single port, followed through to its response.
  task automatic run_op(input vec_t v);
    bit hs = 0, got = 0;
    int lat = 0, en_cnt = 0, other_rsp = 0;
    logic [31:0] d = 32'd0;
    busy_len = v.blen;
    for (int i = 0; i < 10 && !hs; i++) begin
      cyc_begin();
      req_valid = (v.port == 1) ? 2'b10 : 2'b01;
      req_op[v.port] = v.op; req_s1[v.port] = v.s1; req_s2[v.port] = v.s2;
      #1;
      if (ready_rr[v.port]) hs = 1;
    end
    check("tbl_handshake", 32'(hs), 32'd1);
    if (!hs) return;
    check("tbl_other_ready", 32'(ready_rr[1 - v.port]), 32'd0);
    model_last = (v.port == 1);
    for (int i = 0; i < 20 && !got; i++) begin
      cyc_begin();
      req_valid = 2'b00;
      req_s1[v.port] = $urandom(); req_s2[v.port] = $urandom(); req_op[v.port] = 4'hF;
      #1;
      lat++;
      if (alu_en[0]) begin
        en_cnt++;
        check("tbl_alu_s1_stable", alu_s1[0], v.s1);
        check("tbl_alu_s2_stable", alu_s2[0], v.s2);
      end
      if (rsp_rr[1 - v.port]) other_rsp++;
      if (rsp_rr[v.port]) begin got = 1; d = data_rr; end
    end
    check("tbl_rsp_seen", 32'(got), 32'd1);
    check("tbl_rsp_data", d, v.exp);
    check("tbl_latency", 32'(lat), 32'(2 + v.blen));
    check("tbl_en_cycles", 32'(en_cnt), 32'(1 + v.blen));
    check("tbl_other_rsp", 32'(other_rsp), 32'd0);
    cyc_begin();
    #1;
    check("tbl_single_pulse", 32'({rsp_rr, alu_en[0]}), 32'd0);
  endtask

  // One randomized-traffic cycle with scoreboard checks on the RR instance.
  task automatic rnd_cycle(input bit allow_new);
    int g;
    int a;
    exp_t e;
    cyc_begin();
    for (int p = 0; p < 2; p++) begin
      if (allow_new && !pend[p] && $urandom_range(1, 0) == 1) begin
        pend[p] = 1'b1;
        req_op[p] = 4'($urandom_range(10, 0));
        req_s1[p] = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom();
        req_s2[p] = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom();
      end
    end
    req_valid = pend;
    #1;
    if (ready_rr != 2'b00) begin
      check("rnd_accept_while_busy", 32'(sb.size()), 32'd0);
      if (pend == 2'b11) g = model_last ? 0 : 1;
      else g = pend[1] ? 1 : 0;
      check("rnd_grant", 32'(ready_rr), (g == 1) ? 32'd2 : 32'd1);
      a = ready_rr[1] ? 1 : 0;
      busy_len = $urandom_range(3, 0);
      e.port = a;
      e.data = alu_fn(req_op[a], req_s1[a], req_s2[a]);
      e.due = cyc + 2 + busy_len;
      sb.push_back(e);
      model_last = (a == 1);
      pend[a] = 1'b0;
    end else if (pend != 2'b00 && sb.size() == 0) begin
      check("rnd_stall", 32'(ready_rr), 32'd1);
    end
    if (rsp_rr != 2'b00) begin
      if (sb.size() == 0) begin
        check("rnd_spurious_rsp", 32'(rsp_rr), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rnd_rsp_port", 32'(rsp_rr), (e.port == 1) ? 32'd2 : 32'd1);
        check("rnd_rsp_data", data_rr, e.data);
        check("rnd_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  initial begin
    int last_hs;
    int n_hs;
    int fp_rsp0;
    int r0, r1;
    bit done;
    logic [31:0] d0;

    vecs[0] = '{0, OpAdd,  32'd5,       32'd7,          0, 32'd12};
    vecs[1] = '{0, OpSub,  32'd10,      32'd3,          0, 32'd7};
    vecs[2] = '{1, OpXor,  32'hFF,      32'h0F,         0, 32'hF0};
    vecs[3] = '{1, OpMul,  32'h10000,   32'h10000,      3, 32'd0};
    vecs[4] = '{0, OpSltu, 32'd1,       32'hFFFF_FFFF,  0, 32'd1};
    vecs[5] = '{0, OpSlt,  32'd1,       32'hFFFF_FFFF,  0, 32'd0};
    vecs[6] = '{0, OpMul,  32'd3,       32'd5,          2, 32'd15};
    vecs[7] = '{1, OpSra,  32'h8000_0000, 32'd4,        0, 32'hF800_0000};
    for (int p = 0; p < 2; p++) begin
      req_op[p] = OpAdd; req_s1[p] = 32'd1; req_s2[p] = 32'd2;
    end

    // Reset with requests asserted: nothing may be accepted.
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      #1;
      check("rst_ready_rr", 32'(ready_rr), 32'd0);
      check("rst_ready_fp", 32'(ready_fp), 32'd0);
      check("rst_rsp", 32'({rsp_rr, rsp_fp}), 32'd0);
      check("rst_alu_en", 32'(alu_en), 32'd0);
    end
    check("rst_alu_op", 32'(alu_op[0]), 32'd0);
    check("rst_alu_s1", alu_s1[0], 32'd0);
    check("rst_alu_s2", alu_s2[0], 32'd0);
    cyc_begin();
    reset = 1'b0;
    req_valid = 2'b00;
    model_last = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Settle both instances before the tie sequence.
    busy_len = 0;
    req_valid = 2'b00;
    repeat (5) cyc_begin();

    // Continuous tie: RR alternates, fixed priority always serves port 0.
    req_op[0] = OpSub; req_s1[0] = 32'd10; req_s2[0] = 32'd3;
    req_op[1] = OpXor; req_s1[1] = 32'hFF; req_s2[1] = 32'h0F;
    last_hs = -1; n_hs = 0; fp_rsp0 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc_begin();
      req_valid = 2'b11;
      #1;
      if (ready_rr != 2'b00) begin
        check("tie_rr_grant", 32'(ready_rr), model_last ? 32'd1 : 32'd2);
        if (last_hs >= 0) check("tie_spacing", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
        n_hs++;
        model_last = ready_rr[1];
      end
      if (rsp_rr[0]) check("tie_rsp0_data", data_rr, 32'd7);
      if (rsp_rr[1]) check("tie_rsp1_data", data_rr, 32'hF0);
      check("tie_fp_ready1", 32'(ready_fp[1]), 32'd0);
      check("tie_fp_rsp1", 32'(rsp_fp[1]), 32'd0);
      if (rsp_fp[0]) begin
        fp_rsp0++;
        check("tie_fp_rsp0_data", data_fp, 32'd7);
      end
    end
    check("tie_rr_count", 32'(n_hs >= 6), 32'd1);
    check("tie_fp_count", 32'(fp_rsp0 >= 5), 32'd1);

    // Drain the tie traffic, then randomized traffic with a scoreboard.
    req_valid = 2'b00;
    repeat (4) cyc_begin();
    pend = 2'b00;
    for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      rnd_cycle(1'b0);
      if (pend == 2'b00 && sb.size() == 0) done = 1;
    end
    check("rnd_drain", 32'(done), 32'd1);

    // Reset in the middle of a busy multiply on port 1.
    req_valid = 2'b00;
    busy_len = 3;
    repeat (3) cyc_begin();
    req_op[1] = OpMul; req_s1[1] = 32'd6; req_s2[1] = 32'd7;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc_begin();
      req_valid = 2'b10;
      #1;
      if (ready_rr[1]) done = 1;
    end
    check("mid_handshake", 32'(done), 32'd1);
    cyc_begin();
    req_valid = 2'b00;
    cyc_begin();
    #1;
    check("mid_busy_before_reset", 32'({alu_busy[0], alu_en[0]}), 32'd3);
    cyc_begin();
    reset = 1'b1;
    #1;
    check("mid_rst_no_rsp", 32'({rsp_rr, rsp_fp}), 32'd0);
    cyc_begin();
    reset = 1'b0;
    model_last = 1'b1;
    #1;
    check("mid_after_ready", 32'({ready_rr, ready_fp}), 32'd0);
    check("mid_after_rsp", 32'({rsp_rr, rsp_fp}), 32'd0);
    check("mid_after_en", 32'(alu_en), 32'd0);
    check("mid_after_op", 32'(alu_op[0]), 32'd0);
    check("mid_after_s1", alu_s1[0], 32'd0);
    check("mid_after_s2", alu_s2[0], 32'd0);
    busy_len = 0;
    cyc_begin();
    req_op[0] = OpAdd; req_s1[0] = 32'd1; req_s2[0] = 32'd2;
    req_op[1] = OpSub; req_s1[1] = 32'd9; req_s2[1] = 32'd4;
    req_valid = 2'b11;
    #1;
    check("mid_tie_port0", 32'(ready_rr), 32'd1);
    r0 = 0; r1 = 0; d0 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      req_valid = 2'b00;
      #1;
      if (rsp_rr[0]) begin r0++; d0 = data_rr; end
      if (rsp_rr[1]) r1++;
    end
    check("mid_rsp0_count", 32'(r0), 32'd1);
    check("mid_rsp0_data", d0, 32'd3);
    check("mid_rsp1_count", 32'(r1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
